// File: rtl/div_seq_pkg.sv
// Shared types, widths and sign helpers for the multi-cycle DIV/DIVU sequencer.
package div_seq_pkg;

    localparam int REG_W  = 32;
    localparam int DREG_W = 64;
    localparam int CNT_W  = 5;

    localparam logic [REG_W-1:0] ZERO_WORD = '0;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;

    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_e;

    function automatic logic [REG_W-1:0] neg_if(input logic cond, input logic [REG_W-1:0] v);
        logic signed [REG_W-1:0] s;
        s = v;
        return cond ? -s : s;
    endfunction

    // Magnitude of an operand; unsigned operands pass through untouched.
    function automatic logic [REG_W-1:0] abs_op(input logic is_signed, input logic [REG_W-1:0] v);
        return neg_if(is_signed && v[REG_W-1], v);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: trial subtract and quotient-bit select.
module div_step
    import div_seq_pkg::*;
(
    input  logic             rem_hi_i,
    input  logic [REG_W-1:0] rem_i,
    input  logic [REG_W-1:0] divisor_i,
    output logic [REG_W-1:0] rem_o,
    output logic             qbit_o
);

    logic [REG_W:0] trial;

    assign trial = {1'b0, rem_i} - {1'b0, divisor_i};

    // A set rem_hi_i means the shifted remainder already exceeds any 32-bit divisor.
    assign qbit_o = rem_hi_i | ~trial[REG_W];
    assign rem_o  = qbit_o ? trial[REG_W-1:0] : rem_i;

endmodule

// File: rtl/div_seq.sv
// Multi-cycle signed/unsigned 32-bit divider returning {remainder, quotient}.
module div_seq
    import div_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              signed_div_i,
    input  logic [REG_W-1:0]  opdata1_i,
    input  logic [REG_W-1:0]  opdata2_i,
    input  logic              start_i,
    input  logic              annul_i,
    output logic [DREG_W-1:0] result_o,
    output logic              ready_o
);

    div_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [2*REG_W:0]  work_q;
    logic [REG_W-1:0]  divisor_q;
    logic              dvd_neg_q;
    logic              dsr_neg_q;
    logic              signed_q;
    logic [DREG_W-1:0] result_q;
    logic              ready_q;

    logic [REG_W-1:0]  step_rem;
    logic              step_qbit;
    logic [2*REG_W:0]  work_d;
    logic [REG_W-1:0]  quo_fix;
    logic [REG_W-1:0]  rem_fix;

    // work_q = {partial remainder (33b, incl. next dividend bit), dividend/quotient shift, qbit}
    div_step u_step (
        .rem_hi_i  (work_q[2*REG_W]),
        .rem_i     (work_q[2*REG_W-1:REG_W]),
        .divisor_i (divisor_q),
        .rem_o     (step_rem),
        .qbit_o    (step_qbit)
    );

    assign work_d  = {step_rem, work_q[REG_W-1:0], step_qbit};
    assign quo_fix = neg_if(signed_q && (dvd_neg_q ^ dsr_neg_q), work_d[REG_W-1:0]);
    assign rem_fix = neg_if(signed_q && dvd_neg_q, work_d[2*REG_W:REG_W+1]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= DIV_FREE;
            cnt_q     <= '0;
            work_q    <= '0;
            divisor_q <= ZERO_WORD;
            dvd_neg_q <= 1'b0;
            dsr_neg_q <= 1'b0;
            signed_q  <= 1'b0;
            result_q  <= '0;
            ready_q   <= DIV_RESULT_NOT_READY;
        end else begin
            case (state_q)
                DIV_FREE: begin
                    ready_q  <= DIV_RESULT_NOT_READY;
                    result_q <= '0;
                    if (start_i == DIV_START && !annul_i) begin
                        if (opdata2_i == ZERO_WORD) begin
                            state_q <= DIV_BYZERO;
                        end else begin
                            state_q   <= DIV_ON;
                            cnt_q     <= '0;
                            work_q    <= {ZERO_WORD, abs_op(signed_div_i, opdata1_i), 1'b0};
                            divisor_q <= abs_op(signed_div_i, opdata2_i);
                            dvd_neg_q <= opdata1_i[REG_W-1];
                            dsr_neg_q <= opdata2_i[REG_W-1];
                            signed_q  <= signed_div_i;
                        end
                    end
                end
                DIV_BYZERO: begin
                    state_q  <= DIV_END;
                    work_q   <= '0;
                    result_q <= '0;
                end
                DIV_ON: begin
                    if (annul_i) begin
                        state_q <= DIV_FREE;
                        ready_q <= DIV_RESULT_NOT_READY;
                    end else begin
                        work_q <= work_d;
                        cnt_q  <= cnt_q + 1'b1;
                        if (cnt_q == CNT_W'(REG_W - 1)) begin
                            state_q  <= DIV_END;
                            result_q <= {rem_fix, quo_fix};
                            ready_q  <= DIV_RESULT_READY;
                        end
                    end
                end
                DIV_END: begin
                    if (start_i == DIV_STOP || annul_i) begin
                        state_q  <= DIV_FREE;
                        ready_q  <= DIV_RESULT_NOT_READY;
                        result_q <= '0;
                    end else begin
                        ready_q  <= DIV_RESULT_READY;
                    end
                end
                default: state_q <= DIV_FREE;
            endcase
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: driver queues expected results, monitor checks on ready.
module tb_div_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        sdiv;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;

    always #5 clk = ~clk;

    div_seq dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (sdiv),
        .opdata1_i    (op1),
        .opdata2_i    (op2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready)
    );

    typedef struct {
        logic [63:0] res;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pop on each rising ready, check hold stability and idle-zero output.
    logic mon_prev = 1'b0;
    logic mon_have = 1'b0;
    exp_t mon_cur;

    initial begin
        forever begin
            @(negedge clk);
            if (ready === 1'b1) begin
                if (!mon_prev) begin
                    if (sb.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        mon_have = 1'b0;
                        $display("FAIL unexpected_ready: got ready=1 result=%h, required no result (cycle %0d)", result, cyc);
                    end else begin
                        mon_cur  = sb.pop_front();
                        mon_have = 1'b1;
                        check64("result", result, mon_cur.res);
                        check64("latency", 64'(cyc - mon_cur.acc), 64'(mon_cur.lat));
                    end
                end else if (mon_have) begin
                    check64("hold_stable", result, mon_cur.res);
                end
            end else begin
                check64("idle_zero", result, 64'h0);
            end
            mon_prev = ready;
        end
    end

    task automatic wait_ready();
        for (int i = 0; i < 40 && ready !== 1'b1; i++) @(negedge clk);
        if (ready !== 1'b1) begin
            n_chk++;
            n_fail++;
            $display("FAIL ready_timeout: got ready=%b, required 1 within 40 cycles", ready);
        end
    endtask

    // Called at a negedge with the DUT in FREE; returns at a negedge with the DUT in FREE.
    task automatic do_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] e, input int lat, input int hold);
        sdiv  = s;
        op1   = a;
        op2   = b;
        start = 1'b1;
        sb.push_back('{res: e, acc: cyc + 1, lat: lat});
        @(negedge clk);
        sdiv = ~s;
        op1  = ~a;
        op2  = b ^ 32'h0000_0013;
        wait_ready();
        repeat (hold) @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check64("release_ready", {63'b0, ready}, 64'h0);
        check64("release_result", result, 64'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst   = 1'b0;
        sdiv  = 1'b0;
        op1   = '0;
        op2   = '0;
        start = 1'b0;
        annul = 1'b0;
        #1;
        check64("reset_ready", {63'b0, ready}, 64'h0);
        check64("reset_result", result, 64'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        do_div(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 32, 0);
        do_div(1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 32, 0);
        do_div(1'b0, 32'd5, 32'd0, 64'h0, 2, 0);

        // Annul after ten iterations; the next start is accepted on the following edge.
        sdiv  = 1'b0;
        op1   = 32'd123456;
        op2   = 32'd3;
        start = 1'b1;
        repeat (11) @(negedge clk);
        annul = 1'b1;
        start = 1'b0;
        @(negedge clk);
        annul = 1'b0;
        check64("annul_ready", {63'b0, ready}, 64'h0);
        do_div(1'b0, 32'hFFFFFFFF, 32'h10, 64'h0000000F_0FFFFFFF, 32, 0);

        // start together with annul in FREE must not launch a division.
        start = 1'b1;
        annul = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        annul = 1'b0;
        check64("start_annul_ready", {63'b0, ready}, 64'h0);

        do_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 32, 0);
        do_div(1'b0, 32'hFFFFFFFF, 32'h80000001, 64'h7FFFFFFE_00000001, 32, 0);
        do_div(1'b0, 32'hFFFFFFF9, 32'd2, 64'h00000001_7FFFFFFC, 32, 0);
        do_div(1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 32, 5);

        // Asynchronous reset while a result is being held.
        sdiv  = 1'b1;
        op1   = 32'hFFFFFF9C;
        op2   = 32'd7;
        start = 1'b1;
        sb.push_back('{res: 64'hFFFFFFFE_FFFFFFF2, acc: cyc + 1, lat: 32});
        @(negedge clk);
        wait_ready();
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check64("async_rst_end_ready", {63'b0, ready}, 64'h0);
        check64("async_rst_end_result", result, 64'h0);
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b1;
        @(negedge clk);

        // Asynchronous reset in the middle of a division; no result may follow.
        sdiv  = 1'b0;
        op1   = 32'd1000;
        op2   = 32'd3;
        start = 1'b1;
        repeat (8) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check64("async_rst_on_ready", {63'b0, ready}, 64'h0);
        check64("async_rst_on_result", result, 64'h0);
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b1;
        @(negedge clk);

        do_div(1'b1, 32'd100, 32'hFFFFFFF9, 64'h00000002_FFFFFFF2, 32, 0);

        repeat (40) @(negedge clk);
        if (sb.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending results, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
